// File: rtl/ul4_sequencer_if.sv
// Command, logic-unit and response signals of ul4_sequencer; master = command source / unit side, slave = sequencer.
// WIDTH and CNT_W must match the parameters of the attached ul4_sequencer.
interface ul4_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [CNT_W-1:0] cmd_rep;
  logic [WIDTH-1:0] ul_a;
  logic [WIDTH-1:0] ul_b;
  logic [1:0]       ul_s;
  logic [WIDTH-1:0] ul_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_wrap;
  logic             busy;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rep, rsp_ready, ul_out,
    input  cmd_ready, ul_a, ul_b, ul_s, rsp_valid, rsp_data, rsp_wrap, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_rep, rsp_ready, ul_out,
    output cmd_ready, ul_a, ul_b, ul_s, rsp_valid, rsp_data, rsp_wrap, busy
  );
endinterface

// File: rtl/ul4_sequencer.sv
// Issues one command to the 4-bit logic unit for N cycles and returns the result; rsp_valid at accept+N+1, held until rsp_ready.
// No command is accepted until the response is taken; UL4_SEQ_SAT_EN selects saturating instead of wrapping increments.
module ul4_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input logic            clk,
  input logic            reset,
  ul4_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic             wrap_reg;
  logic [WIDTH-1:0] rsp_data_q;
  logic [WIDTH-1:0] ul_a_q;
  logic [WIDTH-1:0] ul_b_q;
  logic [1:0]       ul_s_q;
  logic             cmd_ready_q;
  logic             busy_q;
  logic             rsp_valid_q;

  logic [WIDTH-1:0] sel_opnd;
  logic             sel_ones;
  logic [WIDTH-1:0] next_opnd;

  // next_opnd is both the operand write-back and the captured result value
  always_comb begin
    sel_opnd = op_reg[0] ? b_reg : a_reg;
    sel_ones = op_reg[1] && (sel_opnd == {WIDTH{1'b1}});
`ifdef UL4_SEQ_SAT_EN
    next_opnd = sel_ones ? sel_opnd : bus.ul_out;
`else
    next_opnd = bus.ul_out;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      op_reg      <= '0;
      cnt         <= '0;
      run         <= 1'b0;
      wrap_reg    <= 1'b0;
      rsp_data_q  <= '0;
      ul_a_q      <= '0;
      ul_b_q      <= '0;
      ul_s_q      <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            a_reg       <= bus.cmd_a;
            b_reg       <= bus.cmd_b;
            op_reg      <= bus.cmd_op;
            cnt         <= (bus.cmd_op[1] && (bus.cmd_rep != '0)) ? bus.cmd_rep : CNT_W'(1);
            wrap_reg    <= 1'b0;
            run         <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= EXEC;
          end
        end

        EXEC: begin
          // first EXEC cycle loads the unit-facing registers; the N iterations follow
          if (!run) begin
            ul_a_q <= a_reg;
            ul_b_q <= b_reg;
            ul_s_q <= op_reg;
            run    <= 1'b1;
          end else begin
            if (op_reg == 2'b10) begin
              a_reg  <= next_opnd;
              ul_a_q <= next_opnd;
            end
            if (op_reg == 2'b11) begin
              b_reg  <= next_opnd;
              ul_b_q <= next_opnd;
            end
            if (sel_ones) begin
              wrap_reg <= 1'b1;
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              rsp_data_q  <= next_opnd;
              ul_a_q      <= '0;
              ul_b_q      <= '0;
              ul_s_q      <= '0;
              run         <= 1'b0;
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            wrap_reg    <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          run         <= 1'b0;
          ul_a_q      <= '0;
          ul_b_q      <= '0;
          ul_s_q      <= '0;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_wrap  = wrap_reg;
  assign bus.ul_a      = ul_a_q;
  assign bus.ul_b      = ul_b_q;
  assign bus.ul_s      = ul_s_q;

endmodule
